arm_board_ctrl: RTL and testbench
=================================

Name: arm_board_ctrl

Overview:
Parametrised board front-end between the DE2 pins and the ARM core, the next generation of the direct clock/switch hookup. Synchronises and debounces pushbuttons and provides run/halt/single-step/reset control of the core through a clock-enable and a held reset. Displays one of NUM_PROBES selectable debug words on the seven-segment digits and keeps an enabled-cycle counter on the LEDs. All logic runs on the 50 MHz board clock.

Parameters:
DEBOUNCE_CYCLES, 500000, consecutive stable cycles before a key level is accepted (10 ms at 50 MHz)
RST_CYCLES, 16, cycles core_rst is held after any reset
NUM_PROBES, 4, number of probe words selectable for display (>=1)
PROBE_W, 32, width of each probe word
NUM_DIGITS, 8, seven-segment digits driven (1..8, <= PROBE_W/4)
CNT_W, 16, width of the enabled-cycle counter

Ports:
clk  in  1  board clock (CLOCK_50)
rst  in  1  synchronous, active-high reset
key_n  in  4  raw pushbuttons, active low; [0]=step, [1]=run/halt toggle, [2]=next probe, [3]=core reset
alive_sw  in  2  raw switches; OR drives the alive LED
probe_data  in  NUM_PROBES*PROBE_W  probe words, probe k at [k*PROBE_W +: PROBE_W]
core_en  out  1  clock-enable to the core
core_rst  out  1  reset to the core, active high
hex  out  NUM_DIGITS*7  segments, active low, digit i at [i*7 +: 7], bit 6 = g
probe_sel  out  clog2(NUM_PROBES) (min 1)  currently displayed probe index
run_led  out  1  high in RUN
alive_led  out  1  alive_sw[0] | alive_sw[1], registered
cycle_cnt  out  CNT_W  number of cycles core_en was high, wraps

Behaviour:
- Reset values: core_rst=1, core_en=0, hex all 7'h7F (blank), probe_sel=0, run_led=0, alive_led=0, cycle_cnt=0; FSM in S_RST with hold counter 0.
- Key path per key: 2-FF synchroniser, then a debouncer. Accepted level changes only after the synchronised level differs from the accepted level for DEBOUNCE_CYCLES consecutive cycles; any mismatch restarts the count.
- A press pulse (one cycle) fires on the accepted high-to-low transition. Release produces no pulse. Latency from a clean raw edge to the pulse is 2+DEBOUNCE_CYCLES cycles.
- Holding a key produces exactly one pulse.
- FSM states:
  - S_RST: core_rst=1, core_en=0; after RST_CYCLES cycles go to S_HALT.
  - S_HALT: core_en=0. Reset press -> S_RST; run press -> S_RUN; step press -> S_STEP.
  - S_STEP: core_en=1 for exactly one cycle, then S_HALT.
  - S_RUN: core_en=1 each cycle. Reset press -> S_RST; run press -> S_HALT; step press ignored.
- Simultaneous pulses resolve by priority reset > run > step.
- A reset press in any state, including S_RST, restarts the hold count.
- rst asserted mid-operation returns everything to reset values on the next edge.
- core_en and core_rst are registered and decoded from the state: S_RST means core_rst=1; S_STEP/S_RUN means core_en=1. They are never both high.
- cycle_cnt increments on each cycle core_en=1 and wraps from 2^CNT_W-1 to 0. It clears on entry to S_RST.
- Next-probe press: probe_sel increments, wrapping NUM_PROBES-1 -> 0. With NUM_PROBES=1 it stays 0.
- Display: digit i shows nibble i of the selected probe word. Output is registered, so hex reflects probe_data/probe_sel one cycle later.
- Hex encoding (active low):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E (hex values)
- run_led mirrors state==S_RUN, registered with the state.

Decomposition:
- Package arm_board_pkg: FSM state enum (S_RST, S_HALT, S_STEP, S_RUN), key index constants (KEY_STEP=0, KEY_RUN=1, KEY_NEXT=2, KEY_RST=3), and a nibble-to-segment function.
- One sub-module, key_debounce: synchroniser, debounce counter and press pulse, parametrised by DEBOUNCE_CYCLES, instantiated four times.

Test Plan (DEBOUNCE_CYCLES=8, RST_CYCLES=4 for simulation):
- After rst release, core_rst stays high exactly 4 cycles, then 0, with core_en=0. Raw key_n[0] bounces 1-0-1-0 every 3 cycles, then holds low 20 cycles -> exactly one step pulse, core_en high for exactly 1 cycle, cycle_cnt=1.
- In HALT, press run -> core_en high continuously and run_led=1. After 100 cycles press run -> core_en=0 and cycle_cnt equals the number of enabled cycles, which an independent bench counter checks.
- probe_data = {32'hDEADBEEF, 32'h01234567, 32'h89ABCDEF, 32'h00000000}, i.e. probes 3..0. Press next 5 times:
  - probe_sel sequence is 1,2,3,0,1.
  - With sel=1, hex digit0=0E (F), digit7=00 (8).
- In RUN, assert the run and reset key pulses on the same cycle -> S_RST is entered, core_rst=1, cycle_cnt=0, core_en=0.
- With CNT_W=4, run 17 enabled cycles -> cycle_cnt=1, confirming the wrap.
- Assert rst mid-RUN -> next edge shows core_rst=1, core_en=0, hex all 7F and probe_sel=0. alive_sw=2'b10 -> alive_led=1 one cycle after rst deasserts.

Source files
------------

// File: rtl/arm_board_pkg.sv
// Shared types and helpers for the ARM board front-end.
// Contents: core-control FSM state enum, pushbutton index constants,
//           blank-digit constant and nibble-to-seven-segment encoder.
package arm_board_pkg;

    typedef enum logic [1:0] {
        S_RST  = 2'd0,
        S_HALT = 2'd1,
        S_STEP = 2'd2,
        S_RUN  = 2'd3
    } state_t;

    localparam int KEY_STEP = 0;
    localparam int KEY_RUN  = 1;
    localparam int KEY_NEXT = 2;
    localparam int KEY_RST  = 3;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low segment pattern, bit 6 = g ... bit 0 = a.
    function automatic logic [6:0] seg7(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'h40;
            4'h1:    seg = 7'h79;
            4'h2:    seg = 7'h24;
            4'h3:    seg = 7'h30;
            4'h4:    seg = 7'h19;
            4'h5:    seg = 7'h12;
            4'h6:    seg = 7'h02;
            4'h7:    seg = 7'h78;
            4'h8:    seg = 7'h00;
            4'h9:    seg = 7'h10;
            4'hA:    seg = 7'h08;
            4'hB:    seg = 7'h03;
            4'hC:    seg = 7'h46;
            4'hD:    seg = 7'h21;
            4'hE:    seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Synchronise and debounce one active-low pushbutton, emit a one-cycle press pulse.
// Latency: 2 + DEBOUNCE_CYCLES cycles from a clean raw edge to the pulse.
// Ports: clk, rst (sync, active high), key_n (raw, async), press (pulse on accepted press).
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic          level;   // accepted level, 1 = released
    logic [CW-1:0] cnt;     // consecutive cycles sync2 has disagreed with level

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            level <= 1'b1;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            sync1 <= key_n;
            sync2 <= sync1;
            press <= 1'b0;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level <= sync2;
                cnt   <= '0;
                // Accepting a low while the old level was high is a press.
                press <= level;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/arm_board_ctrl.sv
// DE2 board front-end: debounced keys drive run/halt/step/reset of the ARM core,
// seven-segment display of a selectable probe word, enabled-cycle counter.
// Ports: clk, rst, key_n, alive_sw, probe_data in; core_en, core_rst, hex,
//        probe_sel, run_led, alive_led, cycle_cnt out (all registered).
module arm_board_ctrl
    import arm_board_pkg::*;
#(
    parameter int  DEBOUNCE_CYCLES = 500000,
    parameter int  RST_CYCLES      = 16,
    parameter int  NUM_PROBES      = 4,
    parameter int  PROBE_W         = 32,
    parameter int  NUM_DIGITS      = 8,
    parameter int  CNT_W           = 16,
    localparam int PSEL_W          = (NUM_PROBES > 1) ? $clog2(NUM_PROBES) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [3:0]                    key_n,
    input  logic [1:0]                    alive_sw,
    input  logic [NUM_PROBES*PROBE_W-1:0] probe_data,
    output logic                          core_en,
    output logic                          core_rst,
    output logic [NUM_DIGITS*7-1:0]       hex,
    output logic [PSEL_W-1:0]             probe_sel,
    output logic                          run_led,
    output logic                          alive_led,
    output logic [CNT_W-1:0]              cycle_cnt
);

    localparam int HW = $clog2(RST_CYCLES + 1);
    localparam logic [HW-1:0]     HOLD_LAST = HW'(RST_CYCLES - 1);
    localparam logic [PSEL_W-1:0] SEL_LAST  = PSEL_W'(NUM_PROBES - 1);

    logic [3:0] press;

    for (genvar k = 0; k < 4; k++) begin : g_key
        key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key (
            .clk   (clk),
            .rst   (rst),
            .key_n (key_n[k]),
            .press (press[k])
        );
    end

    state_t        state;
    state_t        nxt_state;
    logic [HW-1:0] hold;
    logic [HW-1:0] nxt_hold;

    // Priority reset > run > step; the hold counter only runs in S_RST and
    // is zeroed whenever S_RST is (re)entered.
    always_comb begin
        nxt_state = state;
        nxt_hold  = hold;
        case (state)
            S_RST: begin
                if (press[KEY_RST]) begin
                    nxt_hold = '0;
                end else if (hold == HOLD_LAST) begin
                    nxt_state = S_HALT;
                    nxt_hold  = '0;
                end else begin
                    nxt_hold = hold + 1'b1;
                end
            end
            S_HALT: begin
                if (press[KEY_RST]) begin
                    nxt_state = S_RST;
                    nxt_hold  = '0;
                end else if (press[KEY_RUN]) begin
                    nxt_state = S_RUN;
                end else if (press[KEY_STEP]) begin
                    nxt_state = S_STEP;
                end
            end
            S_STEP: begin
                nxt_hold  = '0;
                nxt_state = press[KEY_RST] ? S_RST : S_HALT;
            end
            S_RUN: begin
                if (press[KEY_RST]) begin
                    nxt_state = S_RST;
                    nxt_hold  = '0;
                end else if (press[KEY_RUN]) begin
                    nxt_state = S_HALT;
                end
            end
            default: begin
                nxt_state = S_RST;
                nxt_hold  = '0;
            end
        endcase
    end

    // Outputs decoded from the next state so they line up with the state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_RST;
            hold     <= '0;
            core_rst <= 1'b1;
            core_en  <= 1'b0;
            run_led  <= 1'b0;
        end else begin
            state    <= nxt_state;
            hold     <= nxt_hold;
            core_rst <= (nxt_state == S_RST);
            core_en  <= (nxt_state == S_STEP) || (nxt_state == S_RUN);
            run_led  <= (nxt_state == S_RUN);
        end
    end

    logic [PROBE_W-1:0] sel_word;

    always_comb begin
        sel_word = '0;
        for (int k = 0; k < NUM_PROBES; k++) begin
            if (probe_sel == PSEL_W'(k)) begin
                sel_word = probe_data[k*PROBE_W +: PROBE_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_cnt <= '0;
            probe_sel <= '0;
            hex       <= {NUM_DIGITS{SEG_BLANK}};
            alive_led <= 1'b0;
        end else begin
            if (nxt_state == S_RST) begin
                cycle_cnt <= '0;
            end else if (core_en) begin
                cycle_cnt <= cycle_cnt + 1'b1;
            end
            if (press[KEY_NEXT]) begin
                probe_sel <= (probe_sel == SEL_LAST) ? '0 : probe_sel + 1'b1;
            end
            for (int i = 0; i < NUM_DIGITS; i++) begin
                hex[i*7 +: 7] <= seg7(sel_word[i*4 +: 4]);
            end
            alive_led <= alive_sw[0] | alive_sw[1];
        end
    end

endmodule

// File: tb/tb_arm_board_ctrl.sv
// Directed bench for arm_board_ctrl with short debounce/reset timing.
// A second instance with a 4-bit counter shares the stimulus to observe wrap.
module tb_arm_board_ctrl;

    localparam int DB  = 8;
    localparam int RC  = 4;
    localparam int HLD = DB + 6;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [3:0]   key_n = 4'hF;
    logic [1:0]   alive_sw = 2'b00;
    logic [127:0] probe_data;

    logic         core_en, core_rst, run_led, alive_led;
    logic [55:0]  hex;
    logic [1:0]   probe_sel;
    logic [15:0]  cycle_cnt;

    logic         w4_core_en, w4_core_rst, w4_run_led, w4_alive_led;
    logic [55:0]  w4_hex;
    logic [1:0]   w4_probe_sel;
    logic [3:0]   w4_cycle_cnt;

    int checks = 0;
    int errors = 0;
    int en_cnt = 0;

    always #10 clk = ~clk;

    arm_board_ctrl #(.DEBOUNCE_CYCLES(DB), .RST_CYCLES(RC), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .key_n(key_n), .alive_sw(alive_sw), .probe_data(probe_data),
        .core_en(core_en), .core_rst(core_rst), .hex(hex), .probe_sel(probe_sel),
        .run_led(run_led), .alive_led(alive_led), .cycle_cnt(cycle_cnt)
    );

    arm_board_ctrl #(.DEBOUNCE_CYCLES(DB), .RST_CYCLES(RC), .CNT_W(4)) dut_w4 (
        .clk(clk), .rst(rst), .key_n(key_n), .alive_sw(alive_sw), .probe_data(probe_data),
        .core_en(w4_core_en), .core_rst(w4_core_rst), .hex(w4_hex), .probe_sel(w4_probe_sel),
        .run_led(w4_run_led), .alive_led(w4_alive_led), .cycle_cnt(w4_cycle_cnt)
    );

    // Advance n cycles, sampling at the falling edge and counting enabled cycles.
    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            if (core_en) en_cnt++;
        end
    endtask

    task automatic press(input int k);
        key_n[k] = 1'b0;
        tick(HLD);
        key_n[k] = 1'b1;
        tick(HLD);
    endtask

    task automatic test_reset;
        int n;
        rst = 1'b1;
        tick(3);
        checks++;
        if (core_rst !== 1'b1 || core_en !== 1'b0 || run_led !== 1'b0 || alive_led !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: rst=%b en=%b run=%b alive=%b, required 1 0 0 0",
                     core_rst, core_en, run_led, alive_led);
        end
        checks++;
        if (hex !== {8{7'h7F}} || probe_sel !== 2'd0 || cycle_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_data: hex=%h sel=%0d cnt=%0d, required all 7F, 0, 0",
                     hex, probe_sel, cycle_cnt);
        end
        rst = 1'b0;
        n = 0;
        while (core_rst === 1'b1 && n < 20) begin
            n++;
            tick(1);
        end
        checks++;
        if (n != RC || core_en !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold: core_rst high %0d cycles en=%b, required %0d cycles en=0",
                     n, core_en, RC);
        end
        en_cnt = 0;
    endtask

    task automatic test_step_bounce;
        key_n[0] = 1'b1; tick(3);
        key_n[0] = 1'b0; tick(3);
        key_n[0] = 1'b1; tick(3);
        key_n[0] = 1'b0; tick(20);
        key_n[0] = 1'b1; tick(20);
        checks++;
        if (en_cnt != 1 || core_en !== 1'b0) begin
            errors++;
            $display("FAIL step_once: enabled cycles=%0d en=%b, required 1 and 0", en_cnt, core_en);
        end
        checks++;
        if (cycle_cnt !== 16'd1 || w4_cycle_cnt !== 4'd1) begin
            errors++;
            $display("FAIL step_cnt: cnt=%0d w4=%0d, required 1 and 1", cycle_cnt, w4_cycle_cnt);
        end
    endtask

    task automatic test_run_halt;
        int base;
        key_n[1] = 1'b0;
        tick(HLD);
        key_n[1] = 1'b1;
        tick(HLD);
        checks++;
        if (core_en !== 1'b1 || run_led !== 1'b1 || core_rst !== 1'b0) begin
            errors++;
            $display("FAIL run_enter: en=%b run_led=%b rst=%b, required 1 1 0", core_en, run_led, core_rst);
        end
        base = en_cnt;
        tick(100);
        checks++;
        if (en_cnt - base != 100) begin
            errors++;
            $display("FAIL run_continuous: enabled %0d of 100 cycles, required 100", en_cnt - base);
        end
        press(1);
        checks++;
        if (core_en !== 1'b0 || run_led !== 1'b0) begin
            errors++;
            $display("FAIL run_halt: en=%b run_led=%b, required 0 0", core_en, run_led);
        end
        checks++;
        if (cycle_cnt !== en_cnt[15:0]) begin
            errors++;
            $display("FAIL run_count: cnt=%0d, required %0d", cycle_cnt, en_cnt);
        end
    endtask

    task automatic test_probe_select;
        logic [55:0] hex_tab [4];
        logic [1:0]  sel_seq [5];
        hex_tab[0] = {8{7'h40}};
        hex_tab[1] = {7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        hex_tab[2] = {7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78};
        hex_tab[3] = {7'h21, 7'h06, 7'h08, 7'h21, 7'h03, 7'h06, 7'h06, 7'h0E};
        sel_seq[0] = 2'd1; sel_seq[1] = 2'd2; sel_seq[2] = 2'd3; sel_seq[3] = 2'd0; sel_seq[4] = 2'd1;
        checks++;
        if (hex !== hex_tab[0]) begin
            errors++;
            $display("FAIL probe_init_hex: hex=%h, required %h", hex, hex_tab[0]);
        end
        for (int p = 0; p < 5; p++) begin
            press(2);
            checks++;
            if (probe_sel !== sel_seq[p]) begin
                errors++;
                $display("FAIL probe_sel[%0d]: sel=%0d, required %0d", p, probe_sel, sel_seq[p]);
            end
            checks++;
            if (hex !== hex_tab[sel_seq[p]]) begin
                errors++;
                $display("FAIL probe_hex[%0d]: hex=%h, required %h", p, hex, hex_tab[sel_seq[p]]);
            end
        end
        checks++;
        if (hex[6:0] !== 7'h0E || hex[55:49] !== 7'h00) begin
            errors++;
            $display("FAIL probe_digits: d0=%h d7=%h, required 0E 00", hex[6:0], hex[55:49]);
        end
    endtask

    task automatic test_simultaneous;
        int n;
        press(1);
        checks++;
        if (core_en !== 1'b1 || cycle_cnt === 16'd0) begin
            errors++;
            $display("FAIL simul_pre_run: en=%b cnt=%0d, required en=1 cnt>0", core_en, cycle_cnt);
        end
        key_n[1] = 1'b0;
        key_n[3] = 1'b0;
        n = 0;
        while (core_rst !== 1'b1 && n < 30) begin
            n++;
            tick(1);
        end
        checks++;
        if (core_rst !== 1'b1 || core_en !== 1'b0 || cycle_cnt !== 16'd0 || run_led !== 1'b0) begin
            errors++;
            $display("FAIL simul_reset: rst=%b en=%b cnt=%0d run=%b after %0d cycles, required 1 0 0 0",
                     core_rst, core_en, cycle_cnt, run_led, n);
        end
        key_n = 4'hF;
        tick(30);
        checks++;
        if (core_rst !== 1'b0 || core_en !== 1'b0 || run_led !== 1'b0) begin
            errors++;
            $display("FAIL simul_halt: rst=%b en=%b run=%b, required 0 0 0", core_rst, core_en, run_led);
        end
        en_cnt = 0;
    endtask

    task automatic test_wrap;
        for (int s = 0; s < 17; s++) press(0);
        checks++;
        if (cycle_cnt !== 16'd17 || en_cnt != 17) begin
            errors++;
            $display("FAIL wrap_cnt16: cnt=%0d seen=%0d, required 17", cycle_cnt, en_cnt);
        end
        checks++;
        if (w4_cycle_cnt !== 4'd1) begin
            errors++;
            $display("FAIL wrap_cnt4: cnt=%0d, required 1", w4_cycle_cnt);
        end
    endtask

    task automatic test_mid_reset;
        alive_sw = 2'b10;
        press(1);
        checks++;
        if (core_en !== 1'b1 || probe_sel !== 2'd1 || alive_led !== 1'b1) begin
            errors++;
            $display("FAIL midrst_pre: en=%b sel=%0d alive=%b, required 1 1 1", core_en, probe_sel, alive_led);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (core_rst !== 1'b1 || core_en !== 1'b0 || hex !== {8{7'h7F}} || probe_sel !== 2'd0) begin
            errors++;
            $display("FAIL midrst_state: rst=%b en=%b hex=%h sel=%0d, required 1 0 all 7F 0",
                     core_rst, core_en, hex, probe_sel);
        end
        checks++;
        if (alive_led !== 1'b0 || run_led !== 1'b0 || cycle_cnt !== 16'd0) begin
            errors++;
            $display("FAIL midrst_misc: alive=%b run=%b cnt=%0d, required 0 0 0", alive_led, run_led, cycle_cnt);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (alive_led !== 1'b1 || core_rst !== 1'b1) begin
            errors++;
            $display("FAIL midrst_alive: alive=%b rst=%b, required 1 1", alive_led, core_rst);
        end
    endtask

    initial begin
        probe_data = {32'hDEADBEEF, 32'h01234567, 32'h89ABCDEF, 32'h00000000};
        test_reset();
        test_step_bounce();
        test_run_halt();
        test_probe_select();
        test_simultaneous();
        test_wrap();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
